// File: rtl/signed_divider_seq.sv
// signed_divider_seq
//   Sequential two's-complement divider. Operands are reduced to magnitudes
//   at accept, a restoring shift-subtract loop produces one quotient bit per
//   cycle, and a final stage applies the signs. The quotient truncates toward
//   zero and the remainder takes the sign of the dividend.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   divs   signed dividend (WIDTH)
//   div    signed divisor (WIDTH)
//   busy   division in progress
//   done   one-cycle pulse, results valid from this cycle on
//   quo    signed quotient (WIDTH)
//   rem    signed remainder (WIDTH)
//   dz     last operation divided by zero
//   ovf    last operation was most-negative / -1
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | one restoring iteration per cycle, WIDTH cycles
// FIX   | apply signs / special cases, publish results, pulse done
module signed_divider_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] divs,
  input  logic [WIDTH-1:0] div,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // num_q starts as |dividend| and is shifted out MSB-first while quotient
  // bits shift in at the LSB, so it ends up holding |quotient|.
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  // Partial remainder is always < |divisor| <= 2^(WIDTH-1), so WIDTH bits
  // suffice between iterations; only the shifted trial value needs WIDTH+1.
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             zero_q, zero_d;
  logic             over_q, over_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_mag;

  assign shifted = {prem_q, num_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, den_q};
  // With a zero divisor CALC never runs, so num_q still holds |dividend|.
  assign rem_mag = zero_q ? num_q : prem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      den_q     <= '0;
      prem_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      over_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      den_q     <= den_d;
      prem_q    <= prem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      over_q    <= over_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    den_d     = den_q;
    prem_d    = prem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    over_d    = over_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Negating the most-negative value yields 2^(WIDTH-1), which is
          // the correct unsigned magnitude.
          num_d     = divs[WIDTH-1] ? -divs : divs;
          den_d     = div[WIDTH-1] ? -div : div;
          prem_d    = '0;
          quo_neg_d = divs[WIDTH-1] ^ div[WIDTH-1];
          rem_neg_d = divs[WIDTH-1];
          zero_d    = (div == '0);
          over_d    = (divs == {1'b1, {(WIDTH-1){1'b0}}}) && (div == '1);
          dz_d      = 1'b0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_INIT;
          state_d   = (div == '0) ? FIX : CALC;
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          prem_d = trial[WIDTH-1:0];
          num_d  = {num_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH-1:0];
          num_d  = {num_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (zero_q) begin
          quo_d = '1;
        end else begin
          quo_d = quo_neg_q ? -num_q : num_q;
        end
        rem_d   = rem_neg_q ? -rem_mag : rem_mag;
        dz_d    = zero_q;
        ovf_d   = over_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule
